// File: rtl/dmem_win_ctrl_if.sv
// Bundle of CPU, SDRAM-arbiter and memory-side signals around the data-memory window controller.
// Pure wiring: no state and no latency.
// The master side drives CPU/arbiter inputs; the slave (controller) drives request, decode and stall.
interface dmem_win_ctrl_if #(
  parameter int AW      = 25,
  parameter int DMEM_AW = 16,
  parameter int MAW     = 8,
  parameter int NUM_MAT = 2
);
  logic               cpu_valid;
  logic [AW-1:0]      cpu_addr;
  logic               cpu_we;
  logic [15:0]        row_length;
  logic               granted;
  logic               busy;
  logic               request;
  logic               req_write;
  logic [AW-1:0]      start_addr;
  logic [AW-1:0]      length;
  logic [MAW-1:0]     matrix_addr;
  logic [NUM_MAT-1:0] matrix_wr_en;
  logic [DMEM_AW-1:0] dmc_addr;
  logic               stall;
  logic               d_sb;

  modport master (
    output cpu_valid, cpu_addr, cpu_we, row_length, granted, busy,
    input  request, req_write, start_addr, length, matrix_addr,
           matrix_wr_en, dmc_addr, stall, d_sb
  );

  modport slave (
    input  cpu_valid, cpu_addr, cpu_we, row_length, granted, busy,
    output request, req_write, start_addr, length, matrix_addr,
           matrix_wr_en, dmc_addr, stall, d_sb
  );
endinterface

// File: rtl/dmem_win_ctrl.sv
// Keeps one SDRAM window resident in data memory, decodes matrix banks, and refills the window on a miss.
// Decode and stall are combinational; a miss costs optional writeback plus fill, request rises the cycle after.
// The CPU is stalled on a miss and for as long as the FSM is away from IDLE; request holds until granted.
module dmem_win_ctrl #(
  parameter int          AW        = 25,
  parameter int          DMEM_AW   = 16,
  parameter int          NUM_ROWS  = 4,
  parameter int unsigned MAT_BASE  = 'h800,
  parameter int          MAT_DEPTH = 256,
  parameter int          NUM_MAT   = 2
) (
  input  logic           ref_clk,
  input  logic           rst_n,
  dmem_win_ctrl_if.slave bus
);

  localparam int MAW = $clog2(MAT_DEPTH);
  localparam int BW  = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1;
  // Two spare bits so window end and fill-overflow compares never wrap.
  localparam int XW  = AW + 2;

  localparam logic [XW-1:0] MAT_LO = XW'(MAT_BASE);
  localparam logic [XW-1:0] MAT_HI = XW'(MAT_BASE + NUM_MAT * MAT_DEPTH);
  localparam logic [XW-1:0] TOP    = XW'(1) << AW;

  typedef enum logic [1:0] {IDLE, REQ, WAITB, XFER} state_t;

  state_t        state_q, state_d;
  logic          win_valid_q, win_valid_d;
  logic          dirty_q, dirty_d;
  logic [AW-1:0] win_base_q, win_base_d;
  logic [AW-1:0] win_len_q, win_len_d;
  logic [AW-1:0] fill_start_q, fill_start_d;
  logic [AW-1:0] fill_len_q, fill_len_d;
  logic          req_write_q, req_write_d;
  logic [AW-1:0] start_addr_q, start_addr_d;
  logic [AW-1:0] length_q, length_d;

  logic [XW-1:0]      addr_x;
  logic [XW-1:0]      base_x;
  logic [XW-1:0]      end_x;
  logic               mat_hit;
  logic [MAW+BW-1:0]  mat_off;
  logic               win_in;
  logic               win_hit;
  logic               miss;
  logic [AW-1:0]      fill_len_c;
  logic [XW-1:0]      fill_len_x;
  logic [XW-1:0]      rl_x;
  logic [XW-1:0]      s_lo;
  logic [XW-1:0]      s_fit;
  logic [AW-1:0]      fill_start_c;

  // Address decode: matrix region has priority over the resident window.
  assign addr_x  = XW'(bus.cpu_addr);
  assign base_x  = XW'(win_base_q);
  assign end_x   = base_x + XW'(win_len_q);
  assign mat_hit = (addr_x >= MAT_LO) && (addr_x < MAT_HI);
  assign mat_off = (MAW+BW)'(addr_x - MAT_LO);
  assign win_in  = win_valid_q && (addr_x >= base_x) && (addr_x < end_x);
  assign win_hit = !mat_hit && win_in;
  assign miss    = !mat_hit && !win_in;

  // Fill window: one row before the miss, clamped at 0 and at the top of SDRAM.
  assign fill_len_c   = AW'(NUM_ROWS * int'(bus.row_length));
  assign fill_len_x   = XW'(fill_len_c);
  assign rl_x         = XW'(bus.row_length);
  assign s_lo         = (addr_x >= rl_x) ? (addr_x - rl_x) : '0;
  assign s_fit        = ((s_lo + fill_len_x) > TOP) ? (TOP - fill_len_x) : s_lo;
  assign fill_start_c = AW'(s_fit);

  // Writes into matrix banks are suppressed while a refill holds the CPU.
  assign bus.matrix_addr  = mat_off[MAW-1:0];
  assign bus.matrix_wr_en = (mat_hit && bus.cpu_valid && bus.cpu_we && state_q == IDLE)
                            ? (NUM_MAT'(1) << mat_off[MAW +: BW]) : '0;
  assign bus.dmc_addr     = win_hit ? DMEM_AW'(addr_x - base_x) : '0;

  assign bus.request    = (state_q == REQ);
  assign bus.req_write  = req_write_q;
  assign bus.start_addr = start_addr_q;
  assign bus.length     = length_q;
  assign bus.stall      = (bus.cpu_valid && miss) || (state_q != IDLE);
  assign bus.d_sb       = bus.busy && (state_q == WAITB || state_q == XFER);

  // State register.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and window/transfer bookkeeping.
  always_comb begin
    state_d      = state_q;
    win_valid_d  = win_valid_q;
    dirty_d      = dirty_q;
    win_base_d   = win_base_q;
    win_len_d    = win_len_q;
    fill_start_d = fill_start_q;
    fill_len_d   = fill_len_q;
    req_write_d  = req_write_q;
    start_addr_d = start_addr_q;
    length_d     = length_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_valid && miss) begin
          fill_start_d = fill_start_c;
          fill_len_d   = fill_len_c;
          req_write_d  = dirty_q;
          start_addr_d = dirty_q ? win_base_q : fill_start_c;
          length_d     = dirty_q ? win_len_q  : fill_len_c;
          state_d      = REQ;
        end else if (bus.cpu_valid && bus.cpu_we && win_hit) begin
          dirty_d = 1'b1;
        end
      end
      REQ: begin
        if (bus.granted) state_d = WAITB;
      end
      WAITB: begin
        if (bus.busy) state_d = XFER;
      end
      XFER: begin
        if (!bus.busy) begin
          if (req_write_q) begin
            // Writeback done: the old window is clean, now fetch the new one.
            dirty_d      = 1'b0;
            req_write_d  = 1'b0;
            start_addr_d = fill_start_q;
            length_d     = fill_len_q;
            state_d      = REQ;
          end else begin
            win_base_d  = fill_start_q;
            win_len_d   = fill_len_q;
            win_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; reset drops the window and any dirty data.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q  <= 1'b0;
      dirty_q      <= 1'b0;
      win_base_q   <= '0;
      win_len_q    <= '0;
      fill_start_q <= '0;
      fill_len_q   <= '0;
      req_write_q  <= 1'b0;
      start_addr_q <= '0;
      length_q     <= '0;
    end else begin
      win_valid_q  <= win_valid_d;
      dirty_q      <= dirty_d;
      win_base_q   <= win_base_d;
      win_len_q    <= win_len_d;
      fill_start_q <= fill_start_d;
      fill_len_q   <= fill_len_d;
      req_write_q  <= req_write_d;
      start_addr_q <= start_addr_d;
      length_q     <= length_d;
    end
  end

endmodule

// File: tb/tb_dmem_win_ctrl.sv
// Directed bench for the data-memory window controller.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Expected values are hand-computed constants for row_length=200, NUM_ROWS=4.
module tb_dmem_win_ctrl;

  logic ref_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  always #5 ref_clk = ~ref_clk;

  dmem_win_ctrl_if #(.AW(25), .DMEM_AW(16), .MAW(8), .NUM_MAT(2)) bus ();

  dmem_win_ctrl #(
    .AW(25), .DMEM_AW(16), .NUM_ROWS(4), .MAT_BASE('h800), .MAT_DEPTH(256), .NUM_MAT(2)
  ) dut (
    .ref_clk (ref_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  // Grant a pending request and run a 3-cycle transfer; ends right after busy falls is seen.
  task automatic serve();
    bus.granted = 1'b1;
    tick();
    bus.granted = 1'b0;
    bus.busy    = 1'b1;
    tick();
    tick();
    tick();
    bus.busy = 1'b0;
    #1;
    chk("xfer_stall", bus.stall, 1);
    tick();
  endtask

  initial begin
    bus.cpu_valid  = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_we     = 1'b0;
    bus.row_length = 16'd200;
    bus.granted    = 1'b0;
    bus.busy       = 1'b0;

    // 1: reset values
    #1;
    chk("rst_request", bus.request, 0);
    chk("rst_req_write", bus.req_write, 0);
    chk("rst_start", bus.start_addr, 0);
    chk("rst_length", bus.length, 0);
    chk("rst_dmc", bus.dmc_addr, 0);
    chk("rst_wr_en", bus.matrix_wr_en, 0);
    chk("rst_d_sb", bus.d_sb, 0);
    chk("rst_stall", bus.stall, 0);
    @(negedge ref_clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_request", bus.request, 0);

    // 2: cold miss at 'h400 with a slow grant
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 25'h400;
    #1;
    chk("miss_stall", bus.stall, 1);
    chk("miss_req_same_cycle", bus.request, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("req_held", bus.request, 1);
      chk("req_stall", bus.stall, 1);
      tick();
    end
    chk("cold_start", bus.start_addr, 'h338);
    chk("cold_length", bus.length, 800);
    chk("cold_rw", bus.req_write, 0);
    bus.granted = 1'b1;
    tick();
    bus.granted = 1'b0;
    #1;
    chk("req_drop", bus.request, 0);
    chk("d_sb_pre_busy", bus.d_sb, 0);
    bus.busy = 1'b1;
    #1;
    chk("d_sb_busy0", bus.d_sb, 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("d_sb_busy", bus.d_sb, 1);
      chk("busy_stall", bus.stall, 1);
    end
    tick();
    bus.busy = 1'b0;
    #1;
    chk("d_sb_idle", bus.d_sb, 0);
    chk("fall_stall", bus.stall, 1);
    tick();
    chk("hit_stall", bus.stall, 0);
    chk("hit_dmc", bus.dmc_addr, 'hC8);

    // 3: miss near 0 clamps the fill start
    bus.cpu_addr = 25'h50;
    #1;
    chk("low_miss_stall", bus.stall, 1);
    tick();
    chk("low_start", bus.start_addr, 0);
    chk("low_length", bus.length, 800);
    chk("low_rw", bus.req_write, 0);
    serve();
    bus.cpu_addr = 25'h60;
    #1;
    chk("low_hit_stall", bus.stall, 0);
    chk("low_hit_dmc", bus.dmc_addr, 'h60);

    // 4: matrix decode
    bus.cpu_addr = 25'h900;
    bus.cpu_we   = 1'b1;
    #1;
    chk("mat1_wr_en", bus.matrix_wr_en, 'b10);
    chk("mat1_addr", bus.matrix_addr, 'h00);
    chk("mat1_stall", bus.stall, 0);
    tick();
    chk("mat_no_request", bus.request, 0);
    bus.cpu_addr = 25'h8FF;
    #1;
    chk("mat0_wr_en", bus.matrix_wr_en, 'b01);
    chk("mat0_addr", bus.matrix_addr, 'hFF);
    bus.cpu_we = 1'b0;
    #1;
    chk("mat_read_wr_en", bus.matrix_wr_en, 0);

    // 5: dirty window written back before the fill
    bus.cpu_addr = 25'h400;
    #1;
    chk("wb_setup_stall", bus.stall, 1);
    tick();
    serve();
    bus.cpu_we = 1'b1;
    #1;
    chk("wr_hit_stall", bus.stall, 0);
    tick();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 25'h2000;
    #1;
    chk("far_miss_stall", bus.stall, 1);
    tick();
    chk("wb_request", bus.request, 1);
    chk("wb_rw", bus.req_write, 1);
    chk("wb_start", bus.start_addr, 'h338);
    chk("wb_length", bus.length, 800);
    serve();
    chk("fill_request", bus.request, 1);
    chk("fill_stall", bus.stall, 1);
    chk("fill_rw", bus.req_write, 0);
    chk("fill_start", bus.start_addr, 'h1F38);
    chk("fill_length", bus.length, 800);
    serve();
    chk("far_hit_stall", bus.stall, 0);
    chk("far_hit_dmc", bus.dmc_addr, 'hC8);

    // 6: reset in the middle of a transfer
    bus.cpu_addr = 25'h5000;
    tick();
    bus.granted = 1'b1;
    tick();
    bus.granted = 1'b0;
    bus.busy    = 1'b1;
    tick();
    tick();
    chk("xfer_d_sb", bus.d_sb, 1);
    rst_n         = 1'b0;
    bus.cpu_valid = 1'b0;
    #1;
    chk("mid_rst_request", bus.request, 0);
    chk("mid_rst_stall", bus.stall, 0);
    chk("mid_rst_d_sb", bus.d_sb, 0);
    chk("mid_rst_start", bus.start_addr, 0);
    tick();
    rst_n    = 1'b1;
    bus.busy = 1'b0;
    tick();
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 25'h2000;
    #1;
    chk("invalid_win_stall", bus.stall, 1);
    tick();
    chk("re_miss_request", bus.request, 1);
    chk("re_miss_rw", bus.req_write, 0);
    chk("re_miss_start", bus.start_addr, 'h1F38);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
